// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Sits in EX beside the ALU. It stalls the pipeline while it iterates.
// It then holds the quotient or remainder until the next accepted start.
//
// Parameters
//   XLEN      operand/result width; a full divide takes XLEN iterations
//   FAST_PATH 1: divide-by-zero and signed overflow finish in one cycle
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     request; operands and funct3 are sampled when accepted
//   funct3    100 DIV, 101 DIVU, 110 REM, 111 REMU (funct3[2]=0 is ignored)
//   a, b      dividend / divisor (post-forwarding)
//   kill      pipeline flush; aborts the operation in flight
//   busy      registered, high while iterating
//   done      registered, one-cycle pulse when result becomes valid
//   result    quotient or remainder
//   stall_req combinational stall request to the pipeline
module div_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          FAST_PATH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall_req
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  // Holds the dividend magnitude and shifts quotient bits in from the LSB.
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Operand decode for a new request
  logic              op_signed, op_rem, a_neg, b_neg, b_zero, ovf, accept, fast;
  logic [XLEN-1:0]   a_mag, b_mag, min_int, fast_result;

  assign min_int   = {1'b1, {(XLEN-1){1'b0}}};
  assign op_signed = ~funct3[0];
  assign op_rem    = funct3[1];
  assign a_neg     = op_signed & a[XLEN-1];
  assign b_neg     = op_signed & b[XLEN-1];
  assign a_mag     = a_neg ? (~a + XLEN'(1)) : a;
  assign b_mag     = b_neg ? (~b + XLEN'(1)) : b;
  assign b_zero    = (b == '0);
  assign ovf       = op_signed & (a == min_int) & (b == '1);
  assign accept    = start & funct3[2] & ~kill & ((state_q == StIdle) | (state_q == StDone));
  assign fast      = FAST_PATH & (b_zero | ovf);
  assign fast_result = b_zero ? (op_rem ? a : '1) : (op_rem ? '0 : min_int);

  // One restoring step.
  // The shifted partial remainder needs XLEN+1 bits.
  // The borrow out of the trial subtract says whether the divisor fits.
  logic [XLEN:0]     rem_shift, rem_sub;
  logic              fits, last;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fin, rem_fin;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};
  assign fits      = ~rem_sub[XLEN];
  assign rem_nxt   = fits ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_nxt   = {quo_q[XLEN-2:0], fits};
  assign last      = (cnt_q == CntW'(XLEN - 1));
  assign quo_fin   = neg_quo_q ? (~quo_nxt + XLEN'(1)) : quo_nxt;
  assign rem_fin   = neg_rem_q ? (~rem_nxt + XLEN'(1)) : rem_nxt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          // With b == 0 the all-ones quotient must not be negated.
          neg_quo_d = (a_neg ^ b_neg) & ~b_zero;
          neg_rem_d = a_neg;
          is_rem_d  = op_rem;
          if (fast) begin
            state_d  = StDone;
            result_d = fast_result;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CntW'(1);
          // The result is taken from the last step directly.
          // This lets done follow the final busy cycle.
          if (last) begin
            state_d  = StDone;
            result_d = is_rem_q ? rem_fin : quo_fin;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StCalc);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign stall_req = (start & funct3[2] & (state_q == StIdle) & ~kill) | busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (XLEN=32, FAST_PATH=1).
// Expected results are queued when a request is driven.
// They are compared when done pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done, stall_req;
  logic [31:0] result;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] MinInt = 32'h8000_0000;

  div_unit #(
    .XLEN      (32),
    .FAST_PATH (1'b1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of RV32M division semantics
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] av,
                                        input logic [31:0] bv);
    int sa, sb;
    sa = av;
    sb = bv;
    if (bv == 32'd0) return f[1] ? av : 32'hFFFF_FFFF;
    if (!f[0] && av == MinInt && bv == 32'hFFFF_FFFF) return f[1] ? 32'd0 : MinInt;
    case (f[1:0])
      2'b00:   return 32'(sa / sb);
      2'b01:   return av / bv;
      2'b10:   return 32'(sa % sb);
      default: return av % bv;
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) check_eq("unexpected_done", {31'd0, done}, 32'd0);
      else check_eq("result", result, exp_q.pop_front());
    end
  end

  // Drive one start pulse; operands are scrambled afterwards so late sampling shows up
  task automatic pulse_start(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    funct3 = f;
    a      = av;
    b      = bv;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input int n0, input int exp_lat, input int exp_busy);
    int busy_cnt;
    int lat;
    busy_cnt = 0;
    lat      = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = int'(cyc) - n0;
        break;
      end
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    int  n0;
    bit  fast;
    fast = (bv == 32'd0) || (!f[0] && av == MinInt && bv == 32'hFFFF_FFFF);
    exp_q.push_back(model(f, av, bv));
    n0 = int'(cyc);
    pulse_start(f, av, bv);
    wait_done(n0, fast ? 1 : 33, fast ? 0 : 32);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    int          n0;
    logic [2:0]  f;
    logic [31:0] ra, rb;

    rst    = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = 3'b000;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);

    // Directed cases
    run_op(3'b101, 32'd100, 32'd7);
    run_op(3'b111, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op(3'b100, 32'd5, 32'd0);
    run_op(3'b111, 32'd5, 32'd0);
    run_op(3'b100, MinInt, 32'hFFFF_FFFF);
    run_op(3'b110, MinInt, 32'hFFFF_FFFF);
    @(negedge clk);

    // Combinational stall request, kill blocking start, non-M funct3 ignored
    funct3 = 3'b100;
    a      = 32'd40;
    b      = 32'd4;
    start  = 1'b1;
    kill   = 1'b1;
    #1 check_eq("stall_kill", {31'd0, stall_req}, 32'd0);
    kill = 1'b0;
    #1 check_eq("stall_start", {31'd0, stall_req}, 32'd1);
    funct3 = 3'b011;
    #1 check_eq("stall_nonm", {31'd0, stall_req}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq("nonm_ignored", {31'd0, busy}, 32'd0);
    funct3 = 3'b101;
    start  = 1'b1;
    kill   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    @(negedge clk);
    check_eq("kill_start_ignored", {31'd0, busy}, 32'd0);

    // Start pulsed during CALC must not resample operands
    exp_q.push_back(model(3'b101, 32'd100, 32'd7));
    n0 = int'(cyc);
    pulse_start(3'b101, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    pulse_start(3'b101, 32'd1000, 32'd1);
    wait_done(n0, 33, 27);

    // Kill mid-CALC: no done, result unchanged, restart works
    @(negedge clk);
    saved = result;
    pulse_start(3'b101, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check_eq("kill_busy", {31'd0, busy}, 32'd0);
    check_eq("kill_result", result, saved);
    @(negedge clk);
    run_op(3'b101, 32'd9, 32'd3);

    // Reset mid-CALC
    @(negedge clk);
    pulse_start(3'b100, 32'hFFFF_FC18, 32'd7);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_result", result, 32'd0);
    run_op(3'b110, 32'hFFFF_FC18, 32'd7);

    // Random back-to-back ops, each new start lands in the DONE cycle
    for (int i = 0; i < 24; i++) begin
      f = {1'b1, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 5))
        0:       begin ra = $urandom; rb = 32'd0; end
        1:       begin ra = MinInt; rb = 32'hFFFF_FFFF; end
        2:       begin ra = $urandom; rb = 32'($urandom_range(1, 15)); end
        3:       begin ra = 32'($urandom_range(0, 20)); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op(f, ra, rb);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
